// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path: blank patterns and hex decode table.
// Latency: none (constants only).
// Backpressure: none.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam logic [4:0] BLANK_CODE = 5'b10000;

  // Active-low cathode patterns {g,f,e,d,c,b,a}, indexed by hex value.
  localparam logic [6:0] HEX_SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low seven-segment cathode pattern.
// Latency: purely combinational.
// Backpressure: none.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex_dat,
  output logic [6:0] seg_dat
);

  // Table lookup into the shared decode constants.
  always_comb begin
    seg_dat = HEX_SEG_TAB[hex_dat];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned (tear-free) updates.
// Latency: an/seg registered, one cycle after the slot/counter state they reflect.
// Backpressure: none; upd requests merge and are applied at the next frame boundary.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int CW       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] seg0wr,
  input  logic [4:0] seg1wr,
  input  logic [4:0] seg2wr,
  input  logic [4:0] seg3wr,
  input  logic       upd,
  input  logic [3:0] dig_en,
  input  logic [2:0] duty,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done,
  output logic       upd_pend
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic          pend_q, pend_d;
  logic [4:0]    shadow_q [4];
  logic [4:0]    shadow_d [4];
  logic [3:0]    en_sh_q, en_sh_d;
  logic [2:0]    duty_sh_q, duty_sh_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;

  logic          wrap;
  logic          last_slot;
  logic          boundary;
  logic [31:0]   thr;
  logic [4:0]    cur_code;
  logic [6:0]    dec_seg;
  logic          active;

  // Counter, slot rotation, pending request and frame-boundary capture.
  always_comb begin
    wrap         = (cnt_q == CW'(TICK_DIV - 1));
    last_slot    = (slot_q == 2'd3);
    boundary     = wrap && last_slot && (pend_q || upd);
    cnt_d        = wrap ? '0 : cnt_q + 1'b1;
    slot_d       = wrap ? slot_q + 2'd1 : slot_q;
    frame_done_d = wrap && last_slot;
    pend_d       = pend_q;
    shadow_d     = shadow_q;
    en_sh_d      = en_sh_q;
    duty_sh_d    = duty_sh_q;
    if (boundary) begin
      // Same-cycle upd is absorbed by the capture, so pend clears.
      pend_d      = 1'b0;
      shadow_d[0] = seg0wr;
      shadow_d[1] = seg1wr;
      shadow_d[2] = seg2wr;
      shadow_d[3] = seg3wr;
      en_sh_d     = dig_en;
      duty_sh_d   = duty;
    end else if (upd) begin
      pend_d = 1'b1;
    end
  end

  // On-window threshold from the latched duty: (duty+1)/8 of a slot; duty 7 yields TICK_DIV.
  always_comb begin
    thr = ((32'(duty_sh_q) + 32'd1) * 32'(TICK_DIV)) >> 3;
  end

  hex_to_seg7 u_dec (
    .hex_dat (cur_code[3:0]),
    .seg_dat (dec_seg)
  );

  // Drive the selected digit inside its on-window; cnt==0 stays dark to avoid ghosting.
  always_comb begin
    cur_code = shadow_q[slot_q];
    active   = en_sh_q[slot_q] && !cur_code[4] && (cnt_q != '0) && (32'(cnt_q) < thr);
    an_d     = active ? ~(4'b0001 << slot_q) : AN_OFF;
    seg_d    = active ? dec_seg : SEG_BLANK;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      slot_q       <= 2'd0;
      pend_q       <= 1'b0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= BLANK_CODE;
      en_sh_q      <= 4'b1111;
      duty_sh_q    <= 3'd7;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      pend_q       <= pend_d;
      for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
      en_sh_q      <= en_sh_d;
      duty_sh_q    <= duty_sh_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign upd_pend   = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a cycle-index reference model.
// Latency: model predicts registered outputs one cycle after each sampled state.
// Backpressure: not applicable.
module tb_seg_scan_ctrl;

  localparam int TD = 8;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  logic       upd = 1'b0;
  logic [3:0] dig_en = 4'hF;
  logic [2:0] duty = 3'd7;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;
  logic       upd_pend;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: cycles since reset, pending flag, latched display set.
  int         m_n;
  bit         m_pend;
  logic [4:0] m_sh [4];
  logic [3:0] m_en;
  int         m_duty;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_fd;
  logic       e_pend;

  logic [6:0] ref_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_ctrl #(.TICK_DIV(TD), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg0wr     (s0),
    .seg1wr     (s1),
    .seg2wr     (s2),
    .seg3wr     (s3),
    .upd        (upd),
    .dig_en     (dig_en),
    .duty       (duty),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .upd_pend   (upd_pend)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock, predicting outputs from the model and the inputs present this cycle.
  task automatic step();
    logic [3:0] nan;
    logic [6:0] nseg;
    logic       nfd;
    int c, s, thr;
    bit lit;
    nan = 4'hF; nseg = 7'h7F; nfd = 1'b0;
    if (rst) begin
      m_n = 0; m_pend = 0; m_en = 4'hF; m_duty = 7;
      for (int i = 0; i < 4; i++) m_sh[i] = 5'b10000;
    end else begin
      c   = m_n % TD;
      s   = (m_n / TD) % 4;
      thr = ((m_duty + 1) * TD) >> 3;
      lit = m_en[s] && !m_sh[s][4] && c >= 1 && c < thr;
      if (lit) begin
        nan  = 4'hF;
        nan[s] = 1'b0;
        nseg = ref_tab[m_sh[s][3:0]];
      end
      nfd = (c == TD - 1) && (s == 3);
      if (nfd && (m_pend || upd)) begin
        m_sh[0] = s0; m_sh[1] = s1; m_sh[2] = s2; m_sh[3] = s3;
        m_en = dig_en; m_duty = int'(duty); m_pend = 0;
      end else if (upd) begin
        m_pend = 1;
      end
      m_n++;
    end
    @(posedge clk); #1;
    e_an = nan; e_seg = nseg; e_fd = nfd; e_pend = m_pend;
  endtask

  // Step until frame_done is seen; ok=0 if it never appears within the budget.
  task automatic wait_frame(output bit ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (frame_done) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    int fd_cnt;
    rst = 1'b1;
    step(); step();
    n_chk++;
    if ({an, seg, frame_done, upd_pend} !== {4'b1111, 7'b1111111, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got an=%b seg=%b fd=%b pend=%b want 1111 1111111 0 0", an, seg, frame_done, upd_pend);
    end
    rst = 1'b0;
    fd_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (frame_done) fd_cnt++;
      n_chk++;
      if ({an, seg, frame_done, upd_pend} !== {e_an, e_seg, e_fd, e_pend}) begin
        n_fail++;
        $display("FAIL idle_cycle %0d: got %b %b %b %b want %b %b %b %b", k, an, seg, frame_done, upd_pend, e_an, e_seg, e_fd, e_pend);
      end
    end
    n_chk++;
    if (fd_cnt !== 2) begin
      n_fail++;
      $display("FAIL idle_frame_done_count: got %0d want 2", fd_cnt);
    end
  endtask

  task automatic test_digits();
    bit ok;
    int on [4];
    logic [6:0] seen [4];
    logic [6:0] want [4];
    want[0] = 7'b1000000; want[1] = 7'b1111001; want[2] = 7'b0000000; want[3] = 7'b0001110;
    s0 = 5'h00; s1 = 5'h01; s2 = 5'h08; s3 = 5'h0F; dig_en = 4'b1111; duty = 3'd7;
    upd = 1'b1; step(); upd = 1'b0;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL digits_frame_timeout: got no frame_done want pulse"); end
    for (int i = 0; i < 4; i++) begin on[i] = 0; seen[i] = 7'h7F; end
    for (int k = 0; k < 32; k++) begin
      step();
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) begin on[i]++; seen[i] = seg; end
      n_chk++;
      if ({an, seg, frame_done, upd_pend} !== {e_an, e_seg, e_fd, e_pend}) begin
        n_fail++;
        $display("FAIL digits_cycle %0d: got %b %b %b %b want %b %b %b %b", k, an, seg, frame_done, upd_pend, e_an, e_seg, e_fd, e_pend);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (on[i] !== 7 || seen[i] !== want[i]) begin
        n_fail++;
        $display("FAIL digits_slot%0d: got on=%0d seg=%b want on=7 seg=%b", i, on[i], seen[i], want[i]);
      end
    end
  endtask

  task automatic test_duty();
    bit ok;
    int on [4];
    duty = 3'd3;
    upd = 1'b1; step(); upd = 1'b0;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL duty_frame_timeout: got no frame_done want pulse"); end
    for (int i = 0; i < 4; i++) on[i] = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) on[i]++;
      n_chk++;
      if ({an, seg, frame_done, upd_pend} !== {e_an, e_seg, e_fd, e_pend}) begin
        n_fail++;
        $display("FAIL duty_cycle %0d: got %b %b %b %b want %b %b %b %b", k, an, seg, frame_done, upd_pend, e_an, e_seg, e_fd, e_pend);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (on[i] !== 3) begin
        n_fail++;
        $display("FAIL duty_on_slot%0d: got %0d want 3", i, on[i]);
      end
    end
  endtask

  task automatic test_tearing();
    bit ok;
    bit hit;
    int on2;
    logic [6:0] old2, new2;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL tear_sync_timeout: got no frame_done want pulse"); end
    for (int k = 0; k < 9; k++) step();
    upd = 1'b1; step(); upd = 1'b0;
    s2 = 5'h0A; duty = 3'd7;
    old2 = 7'h7F; hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      step();
      if (frame_done) hit = 1;
      else begin
        if (an == 4'b1011) old2 = seg;
        n_chk++;
        if (upd_pend !== 1'b1) begin
          n_fail++;
          $display("FAIL tear_pend %0d: got %b want 1", k, upd_pend);
        end
      end
      n_chk++;
      if ({an, seg, frame_done, upd_pend} !== {e_an, e_seg, e_fd, e_pend}) begin
        n_fail++;
        $display("FAIL tear_cycle %0d: got %b %b %b %b want %b %b %b %b", k, an, seg, frame_done, upd_pend, e_an, e_seg, e_fd, e_pend);
      end
    end
    n_chk++;
    if (!hit || old2 !== 7'b0000000) begin
      n_fail++;
      $display("FAIL tear_old_digit2: got seg=%b boundary=%0d want 0000000 1", old2, hit);
    end
    on2 = 0; new2 = 7'h7F;
    for (int k = 0; k < 32; k++) begin
      step();
      if (an == 4'b1011) begin on2++; new2 = seg; end
    end
    n_chk++;
    if (new2 !== 7'b0001000 || on2 !== 7) begin
      n_fail++;
      $display("FAIL tear_new_digit2: got seg=%b on=%0d want 0001000 7", new2, on2);
    end
  endtask

  task automatic test_blank_enable();
    bit ok;
    int on [4];
    logic [6:0] seen [4];
    s1 = 5'h13; dig_en = 4'b0111;
    upd = 1'b1; step(); upd = 1'b0;
    wait_frame(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL blank_frame_timeout: got no frame_done want pulse"); end
    for (int i = 0; i < 4; i++) begin on[i] = 0; seen[i] = 7'h7F; end
    for (int k = 0; k < 32; k++) begin
      step();
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) begin on[i]++; seen[i] = seg; end
      n_chk++;
      if ({an, seg, frame_done, upd_pend} !== {e_an, e_seg, e_fd, e_pend}) begin
        n_fail++;
        $display("FAIL blank_cycle %0d: got %b %b %b %b want %b %b %b %b", k, an, seg, frame_done, upd_pend, e_an, e_seg, e_fd, e_pend);
      end
    end
    n_chk++;
    if (on[1] !== 0 || on[3] !== 0) begin
      n_fail++;
      $display("FAIL blank_dark_digits: got on1=%0d on3=%0d want 0 0", on[1], on[3]);
    end
    n_chk++;
    if (on[0] !== 7 || on[2] !== 7 || seen[0] !== 7'b1000000 || seen[2] !== 7'b0001000) begin
      n_fail++;
      $display("FAIL blank_live_digits: got on0=%0d on2=%0d seg0=%b seg2=%b want 7 7 1000000 0001000", on[0], on[2], seen[0], seen[2]);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int lit_cnt;
    s1 = 5'h01; dig_en = 4'hF;
    wait_frame(ok);
    for (int k = 0; k < 16; k++) step();
    upd = 1'b1; step(); upd = 1'b0;
    step();
    n_chk++;
    if (upd_pend !== 1'b1) begin n_fail++; $display("FAIL rstmid_pend_before: got %b want 1", upd_pend); end
    rst = 1'b1; step(); rst = 1'b0;
    n_chk++;
    if ({an, seg, frame_done, upd_pend} !== {4'b1111, 7'b1111111, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_after: got an=%b seg=%b fd=%b pend=%b want 1111 1111111 0 0", an, seg, frame_done, upd_pend);
    end
    lit_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (an != 4'hF) lit_cnt++;
      n_chk++;
      if ({an, seg, frame_done, upd_pend} !== {e_an, e_seg, e_fd, e_pend}) begin
        n_fail++;
        $display("FAIL rstmid_cycle %0d: got %b %b %b %b want %b %b %b %b", k, an, seg, frame_done, upd_pend, e_an, e_seg, e_fd, e_pend);
      end
    end
    n_chk++;
    if (lit_cnt !== 0) begin n_fail++; $display("FAIL rstmid_blank: got %0d lit cycles want 0", lit_cnt); end
    upd = 1'b1; step(); upd = 1'b0;
    wait_frame(ok);
    lit_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (an != 4'hF) lit_cnt++;
    end
    n_chk++;
    if (!ok || lit_cnt !== 28) begin
      n_fail++;
      $display("FAIL rstmid_resume: got lit=%0d frame=%0d want 28 1", lit_cnt, ok);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      s0 = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom); s3 = 5'($urandom);
      dig_en = 4'($urandom); duty = 3'($urandom);
      upd = ($urandom_range(0, 15) == 0);
      step();
      n_chk++;
      if ({an, seg, frame_done, upd_pend} !== {e_an, e_seg, e_fd, e_pend}) begin
        n_fail++;
        $display("FAIL random_cycle %0d: got %b %b %b %b want %b %b %b %b", k, an, seg, frame_done, upd_pend, e_an, e_seg, e_fd, e_pend);
      end
      n_chk++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL random_onehot %0d: got an=%b want at most one low", k, an);
      end
    end
    upd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_digits();
    test_duty();
    test_tearing();
    test_blank_enable();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit seven-segment display. It takes the four 5-bit digit codes from the write logic and shares the single cathode bus between the four digits by rotating the anode enables. New codes are applied only at frame boundaries, so a digit never shows a mix of old and new values. Per-digit enables and a brightness (duty) setting are also latched at the frame boundary. It sits between the entry/write logic and the board's anode/cathode pins.

Parameters:
TICK_DIV, 50000, clock cycles per digit slot (100 MHz gives 2 kHz per slot and a 500 Hz frame); minimum 8.
CW, 16, width of the slot counter; must satisfy 2^CW >= TICK_DIV.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
seg0wr  input  5  digit 0 code; bit4 = blank, bits[3:0] = hex value
seg1wr  input  5  digit 1 code, same format
seg2wr  input  5  digit 2 code, same format
seg3wr  input  5  digit 3 code, same format
upd  input  1  one-cycle pulse requesting capture of seg*wr, dig_en and duty
dig_en  input  4  per-digit enable, bit i = digit i
duty  input  3  brightness level 0..7; on-window is (duty+1)/8 of each slot
an  output  4  anode enables, active-low
seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low
frame_done  output  1  one-cycle pulse marking the start of a new frame
upd_pend  output  1  high while a captured update request is waiting for the frame boundary

Behaviour:
- Reset (synchronous, rst=1 at the clock edge) sets:
  - cnt=0, slot=0, pend=0
  - shadow[0..3]=5'b10000 (blank), en_sh=4'b1111, duty_sh=7, thr=TICK_DIV
  - an=4'b1111, seg=7'b1111111, frame_done=0
- Reset mid-frame discards any pending update. rst has priority over upd.
- Slot counter:
  - cnt increments each cycle.
  - At cnt==TICK_DIV-1, cnt wraps to 0 and slot advances 0→1→2→3→0.
- Update request:
  - upd=1 sets pend. upd_pend = pend.
  - Repeated upd pulses before the boundary merge into one request.
- Frame boundary is the cycle where cnt==TICK_DIV-1, slot==3 and pend==1 (or upd==1 in that same cycle). At the closing edge of that cycle:
  - shadow[i] ← seg{i}wr
  - en_sh ← dig_en, duty_sh ← duty
  - thr ← ((duty+1)*TICK_DIV)>>3
  - pend ← 0
- The inputs sampled are those present in the boundary cycle. Inputs that change between the upd pulse and the boundary are taken at their boundary value.
- frame_done is registered. It pulses for one cycle in the cycle after every slot-3 wrap, whether or not a capture happened.
- Active condition for slot s: en_sh[s] && !shadow[s][4] && cnt>=1 && cnt<thr.
  - cnt==0 is a one-cycle dead time against ghosting.
  - duty=7 gives thr=TICK_DIV, so the digit is on for cnt 1..TICK_DIV-1.
- Registered outputs, latency 1: an/seg in cycle t+1 reflect slot/cnt/shadow in cycle t.
  - When active: an has only bit s low, and seg = decode(shadow[s][3:0]).
  - Otherwise: an=4'b1111 and seg=7'b1111111.
- Decode table (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Invariant: at most one bit of an is low in any cycle.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_BLANK=7'b1111111
  - AN_OFF=4'b1111
  - BLANK_CODE=5'b10000
  - the 16-entry hex-to-segment constant table
- One sub-module, hex_to_seg7: purely combinational, 4-bit in, 7-bit active-low out. It is used once on the selected shadow value.
- Counter, slot, pending, shadow and output registers stay in seg_scan_ctrl.

Test Plan:
All scenarios use TICK_DIV=8.
1. Reset, then run 64 cycles with no upd → an=4'b1111 and seg=7'b1111111 throughout; frame_done pulses every 32 cycles.
2. seg*wr={0x0,0x1,0x8,0xF}, dig_en=4'b1111, duty=7, one upd pulse → after the next frame_done:
   - slot 0: an=1110, seg=1000000
   - slot 1: an=1101, seg=1111001
   - slot 2: an=1011, seg=0000000
   - slot 3: an=0111, seg=0001110
   - each digit is on for 7 of 8 cycles.
3. duty=3, upd → each digit is on for exactly 3 cycles per slot (cnt 1..3); the remaining 5 cycles are off.
4. Tearing check: upd in slot 1, then change seg2wr to 0xA before the boundary → the old digit stays visible until the frame ends; the new frame shows A on digit 2; upd_pend is high from the cycle after upd until the boundary.
5. seg1wr bit4=1 together with dig_en=4'b0111 → digits 1 and 3 are never lit; digits 0 and 2 are unaffected.
6. Assert rst in slot 2 with pend=1 → the next cycle shows an=1111 and upd_pend=0; the display stays blank until a new upd completes a frame.
